// File: rtl/reduce_sweep_ctrl.sv
// Built-in self-check for the shared AND/OR/XOR reduction gates: sweeps every input vector and counts mismatches.
// Define RED_LOG_EN to add first-failure capture (first_fail_vec, first_fail_mask).
module reduce_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] gate_in,
  input  logic             and_res,
  input  logic             or_res,
  input  logic             xor_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_cnt
`ifdef RED_LOG_EN
  ,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic [2:0]       first_fail_mask
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // DRIVE | vector on gate_in, settle counter loaded
  // WAIT  | gates settling, SETTLE cycles
  // CHECK | compare gate outputs, advance vector
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [3:0] settle_cnt;
  logic [2:0] mism;
  logic       last_vec;

  // Case inequality so an X/Z gate output counts as a failure.
  assign mism = {xor_res !== (^gate_in), or_res !== (|gate_in), and_res !== (&gate_in)};
  assign last_vec = &gate_in;

  assign busy = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   state_d = WAIT;
      WAIT:    if (settle_cnt == 4'd1) state_d = CHECK;
      CHECK:   state_d = last_vec ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && busy) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_in         <= '0;
      settle_cnt      <= '0;
      pass            <= 1'b0;
      err_cnt         <= '0;
`ifdef RED_LOG_EN
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
`endif
    end else if (abort && busy) begin
      // err_cnt and first-fail capture keep their partial values
      gate_in <= '0;
      pass    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            gate_in         <= '0;
            err_cnt         <= '0;
            pass            <= 1'b0;
`ifdef RED_LOG_EN
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
`endif
          end
        end
        DRIVE: settle_cnt <= SETTLE_W;
        WAIT:  settle_cnt <= settle_cnt - 4'd1;
        CHECK: begin
          if (|mism) begin
            err_cnt <= err_cnt + (WIDTH+1)'(1);
`ifdef RED_LOG_EN
            if (err_cnt == '0) begin
              first_fail_vec  <= gate_in;
              first_fail_mask <= mism;
            end
`endif
          end
          if (last_vec) begin
            gate_in <= '0;
            pass    <= (err_cnt == '0) && !(|mism);
          end else begin
            gate_in <= gate_in + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
